// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory-wait timeout.
// Optional performance counters are enabled by defining SEQ_PERF_CNT_EN.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_load,
  input  logic             reg_write,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             branch,
  input  logic             jump,
  input  logic             alu_zero,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             halted,
  output logic [2:0]       state_dbg,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                timeout_hit;

  // wait_q holds the number of earlier un-acked cycles, so the limit is hit on the MEM_TIMEOUT-th one
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LIMIT);
  assign state_dbg   = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 2'd0;
    pc_write = 1'b0;
    pc_sel   = 2'd0;
    halted   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (!(reg_write || mem_write || branch || jump)) state_d = S_TRAP;
        else                                             state_d = S_EXEC;
      end
      S_EXEC: begin
        if (branch) begin
          pc_write = 1'b1;
          pc_sel   = alu_zero ? 2'd1 : 2'd0;
        end else if (jump) begin
          state_d = S_WB;
        end else if (mem_read || mem_write) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mem_write;
        if (dmem_ack) begin
          if (mem_write) pc_write = 1'b1;
          else           state_d  = S_WB;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        rf_we    = 1'b1;
        pc_write = 1'b1;
        if (jump) begin
          wb_sel = 2'd2;
          pc_sel = 2'd2;
        end else if (mem_read) begin
          wb_sel = 2'd1;
        end
      end
      S_TRAP: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // pc_write marks exactly the retiring cycle
    if (pc_write) state_d = run ? S_FETCH : S_IDLE;
  end

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             stall_evt;

  assign stall_evt = ((state_q == S_FETCH) && !imem_ack) || ((state_q == S_MEM) && !dmem_ack);

  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if (pc_write)  retired_d = retired_q + CNT_W'(1);
    if (stall_evt) stall_d   = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retired_cnt = retired_q;
  assign stall_cnt   = stall_q;
`else
  assign retired_cnt = '0;
  assign stall_cnt   = '0;
`endif

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle FSM that sequences one instruction at a time through fetch, decode, execute, memory and writeback.
- Consumes the decoder's control flags (reg_write, mem_read, mem_write, branch, jump) and the ALU zero flag.
- Drives the instruction/data memory handshakes, PC update, register-file write enable and writeback mux.
- Sits between the instruction decoder and the ALU/register-file/memory datapath.

Parameters:
- MEM_TIMEOUT, 16: max wait cycles for imem_ack/dmem_ack before entering TRAP; 0 disables the timeout.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- run  in  1  level; allows the next fetch to start.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  instruction valid; sampled only while imem_req=1.
- ir_load  out  1  one-cycle pulse that loads the instruction register.
- reg_write, mem_read, mem_write, branch, jump  in  1 each  decoder flags; valid from DECODE onward.
- alu_zero  in  1  ALU zero flag; valid in EXEC.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  store qualifier; equals mem_write while dmem_req=1, else 0.
- dmem_ack  in  1  data access complete; sampled only while dmem_req=1.
- rf_we  out  1  register-file write enable pulse.
- wb_sel  out  2  writeback source: 0 ALU, 1 load data, 2 PC+4.
- pc_write  out  1  PC update pulse.
- pc_sel  out  2  next-PC source: 0 PC+4, 1 branch target, 2 jump target.
- halted  out  1  high while in TRAP.
- state_dbg  out  3  encoded current state.
- retired_cnt  out  CNT_W  instructions retired.
- stall_cnt  out  CNT_W  memory wait cycles.

Behaviour:
- Reset:
  - All outputs are 0 one cycle after rst is sampled high; state goes to IDLE (encoding 0); counters clear.
  - rst mid-instruction abandons the instruction, including any outstanding request; the request drops the next cycle.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: go to FETCH when run=1; otherwise stay.
- FETCH:
  - imem_req=1 until imem_ack; zero-wait ack is allowed (ack in the first FETCH cycle).
  - On ack: ir_load=1 in the same cycle, then go to DECODE.
- DECODE: single cycle.
  - If none of reg_write, mem_write, branch, jump is set, the opcode is illegal: go to TRAP.
  - Otherwise go to EXEC.
- EXEC: single cycle.
  - branch: pc_write=1, pc_sel=alu_zero?1:0; instruction retires here.
  - jump: go to WB.
  - mem_read or mem_write: go to MEM.
  - Otherwise (R-type): go to WB.
- MEM:
  - dmem_req=1 until dmem_ack.
  - Store: on ack, pc_write=1, pc_sel=0; retires.
  - Load: on ack, go to WB.
- WB: single cycle; rf_we=1, pc_write=1; retires.
  - Load: wb_sel=1, pc_sel=0.
  - Jump: wb_sel=2, pc_sel=2. PC+4 is captured by the register file at the same edge that updates the PC.
  - R-type: wb_sel=0, pc_sel=0.
- After a retire: go to FETCH if run=1, else IDLE. Deasserting run mid-instruction never aborts it.
- pc_write pulses exactly once per retired instruction. rf_we pulses at most once, and only in WB.
- Outside their active states: wb_sel and pc_sel hold 0, and dmem_we is 0.
- Timeout:
  - A wait counter counts consecutive un-acked request cycles in FETCH or MEM.
  - When the counter equals MEM_TIMEOUT with no ack: go to TRAP and drop the request.
  - An ack in the same cycle the limit is hit wins; no trap.
  - The counter clears on entry to FETCH and to MEM.
- TRAP: sticky until rst; halted=1, all other control outputs 0, acks ignored.

Optional Feature:
- Macro: SEQ_PERF_CNT_EN.
- Defined:
  - retired_cnt increments on every retire.
  - stall_cnt increments on every FETCH or MEM cycle with request=1 and ack=0.
  - Both are CNT_W wide, wrap modulo 2^CNT_W, clear on rst, and freeze in TRAP.
- Undefined: both ports remain in the interface, tied to constant 0; no counter flops are synthesized.

Test Plan:
- R-type, zero-wait acks, run=1:
  - required sequence IDLE, FETCH, DECODE, EXEC, WB, FETCH;
  - rf_we=1, wb_sel=0, pc_write=1, pc_sel=0 in WB;
  - 4 cycles per instruction; retired_cnt 0->1.
- Load with dmem_ack delayed 3 cycles:
  - dmem_req high for 4 cycles, dmem_we=0;
  - then WB with wb_sel=1, rf_we=1;
  - stall_cnt=3 (macro on).
- BEQ with alu_zero=1, then with alu_zero=0:
  - required pc_sel=1, then 0, with pc_write in EXEC;
  - rf_we stays 0; next state FETCH.
- JAL: WB asserts rf_we=1, wb_sel=2, pc_sel=2, pc_write=1 in the same cycle.
- All decoder flags 0 in DECODE:
  - TRAP next cycle, halted=1, imem_req stays 0 despite run=1;
  - rst=1 for one cycle returns to IDLE with all outputs 0.
- MEM_TIMEOUT=4, imem_ack never asserted:
  - imem_req high 4 cycles, then TRAP;
  - repeat with ack on the 4th cycle: required no trap, DECODE follows;
  - run dropped during MEM: store completes, then IDLE.
